// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings and payload types for bus initiators and their helpers.
package ahb_lite_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // What the data phase needs to remember about the transfer it is finishing.
  typedef struct packed {
    logic       write;
    logic [2:0] size;
    logic [1:0] addr_lo;
  } dphase_t;

  typedef enum logic [1:0] {
    ERR_IDLE,
    ERR_CYC2,
    ERR_CYC2_ABT,
    ERR_ABORT
  } err_state_e;

endpackage

// File: rtl/ahb_lite_master_if.sv
// AHB-Lite bus signal bundle between one initiator and the slave-side fabric.
interface ahb_lite_master_if;
  import ahb_lite_pkg::*;

  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [2:0]        HBURST;
  logic [3:0]        HPROT;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADY;
  logic              HRESP;

  modport master (
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_lane_steer.sv
// Byte-lane steering: replicate narrow write data across lanes, pull narrow read data down.
module ahb_lane_steer
  import ahb_lite_pkg::*;
(
  input  logic [2:0]        wr_size,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] wr_data_rep_c,
  input  logic [2:0]        rd_size,
  input  logic [1:0]        rd_addr_lo,
  input  logic [DATA_W-1:0] rd_bus,
  output logic [DATA_W-1:0] rd_data_c
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    wr_data_rep_c = wr_data;
    case (wr_size)
      HSIZE_BYTE: wr_data_rep_c = {4{wr_data[7:0]}};
      HSIZE_HALF: wr_data_rep_c = {2{wr_data[15:0]}};
      default:    wr_data_rep_c = wr_data;
    endcase
  end

  // Lane select follows the little-endian AHB byte-lane mapping.
  always_comb begin
    rd_byte = rd_bus[7:0];
    case (rd_addr_lo)
      2'd1:    rd_byte = rd_bus[15:8];
      2'd2:    rd_byte = rd_bus[23:16];
      2'd3:    rd_byte = rd_bus[31:24];
      default: rd_byte = rd_bus[7:0];
    endcase
    rd_half = rd_addr_lo[1] ? rd_bus[31:16] : rd_bus[15:0];

    rd_data_c = rd_bus;
    case (rd_size)
      HSIZE_BYTE: rd_data_c = DATA_W'(rd_byte);
      HSIZE_HALF: rd_data_c = DATA_W'(rd_half);
      default:    rd_data_c = rd_bus;
    endcase
  end

endmodule

// File: rtl/ahb_lite_master.sv
// Single-transfer AHB-Lite initiator: valid/ready commands in, pipelined NONSEQ SINGLE
// transfers on the bus, one in-order response per command out.
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_abort,
  ahb_lite_master_if.master bus
);

  logic [1:0]        htrans_q;
  logic [ADDR_W-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;
  logic [DATA_W-1:0] hwdata_q;
  logic [DATA_W-1:0] ap_wdata_q;
  logic              dp_valid_q;
  dphase_t           dp_q;
  err_state_e        err_state_q;
  err_state_e        err_state_d;

  logic              err_cyc1;
  logic              accept_c;
  logic              ap_nonseq_c;
  logic              err_start_c;
  logic              emit_abort_c;
  logic [DATA_W-1:0] wr_rep_c;
  logic [DATA_W-1:0] rd_ext_c;

  ahb_lane_steer u_steer (
    .wr_size       (hsize_q),
    .wr_data       (ap_wdata_q),
    .wr_data_rep_c (wr_rep_c),
    .rd_size       (dp_q.size),
    .rd_addr_lo    (dp_q.addr_lo),
    .rd_bus        (bus.HRDATA),
    .rd_data_c     (rd_ext_c)
  );

  assign ap_nonseq_c = (htrans_q == HTRANS_NONSEQ);
  assign err_cyc1    = (err_state_q == ERR_CYC2) || (err_state_q == ERR_CYC2_ABT);
  assign cmd_ready   = bus.HREADY & ~err_cyc1;
  assign accept_c    = cmd_valid & cmd_ready;
  assign err_start_c = dp_valid_q & (bus.HRESP == HRESP_ERROR) & ~bus.HREADY
                     & (err_state_q == ERR_IDLE);

  // Error sequencing: wait out the second ERROR cycle, then release a cancelled command's response.
  always_comb begin
    err_state_d  = err_state_q;
    emit_abort_c = 1'b0;
    case (err_state_q)
      ERR_IDLE: begin
        if (err_start_c) err_state_d = ap_nonseq_c ? ERR_CYC2_ABT : ERR_CYC2;
      end
      ERR_CYC2: begin
        if (bus.HREADY) err_state_d = ERR_IDLE;
      end
      ERR_CYC2_ABT: begin
        if (bus.HREADY) err_state_d = ERR_ABORT;
      end
      ERR_ABORT: begin
        emit_abort_c = 1'b1;
        err_state_d  = ERR_IDLE;
      end
      default: err_state_d = ERR_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) err_state_q <= ERR_IDLE;
    else          err_state_q <= err_state_d;
  end

  // Address phase, data phase and response pipeline; everything advances on HREADY.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= '0;
      hwrite_q   <= 1'b0;
      hsize_q    <= '0;
      hwdata_q   <= '0;
      ap_wdata_q <= '0;
      dp_valid_q <= 1'b0;
      dp_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rsp_abort  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (bus.HREADY) begin
        if (accept_c) begin
          htrans_q   <= HTRANS_NONSEQ;
          haddr_q    <= cmd_addr;
          hwrite_q   <= cmd_write;
          hsize_q    <= cmd_size;
          ap_wdata_q <= cmd_wdata;
        end else begin
          htrans_q <= HTRANS_IDLE;
        end

        dp_valid_q <= ap_nonseq_c;
        if (ap_nonseq_c) begin
          dp_q <= '{write: hwrite_q, size: hsize_q, addr_lo: haddr_q[1:0]};
          if (hwrite_q) hwdata_q <= wr_rep_c;
        end

        if (dp_valid_q) begin
          rsp_valid <= 1'b1;
          rsp_err   <= (bus.HRESP == HRESP_ERROR);
          rsp_abort <= 1'b0;
          rsp_rdata <= dp_q.write ? '0 : rd_ext_c;
        end
      end else if (err_start_c && ap_nonseq_c) begin
        // First ERROR cycle: withdraw the queued address phase so it never reaches the slave.
        htrans_q <= HTRANS_IDLE;
      end

      if (emit_abort_c) begin
        rsp_valid <= 1'b1;
        rsp_err   <= 1'b1;
        rsp_abort <= 1'b1;
        rsp_rdata <= '0;
      end
    end
  end

  assign bus.HADDR  = haddr_q;
  assign bus.HTRANS = htrans_q;
  assign bus.HWRITE = hwrite_q;
  assign bus.HSIZE  = hsize_q;
  assign bus.HBURST = HBURST_SINGLE;
  assign bus.HPROT  = HPROT_VAL;
  assign bus.HWDATA = hwdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Directed bench for ahb_lite_master: the bench plays the slave and checks bus and responses.
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_abort;

  ahb_lite_master_if bus_if ();

  ahb_lite_master #(.HPROT_VAL(4'b0011)) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_size  (cmd_size),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_abort (rsp_abort),
    .bus       (bus_if)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    int          cyc;
    logic        err;
    logic        abort;
    logic [31:0] rdata;
  } rsp_t;

  rsp_t rsp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always @(posedge HCLK) cyc <= cyc + 1;

  // Response log, sampled mid-cycle.
  always @(negedge HCLK) begin
    if (HRESETn === 1'b1 && rsp_valid === 1'b1)
      rsp_q.push_back('{cyc: cyc, err: rsp_err, abort: rsp_abort, rdata: rsp_rdata});
  end

  // Commands must be legal and aligned.
  always @(posedge HCLK) begin
    if (HRESETn === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
      assert (cmd_size <= HSIZE_WORD) else $error("illegal cmd_size %0d", cmd_size);
      assert ((cmd_addr & ((32'd1 << cmd_size) - 32'd1)) == 32'd0)
        else $error("misaligned cmd_addr %h size %0d", cmd_addr, cmd_size);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [2:0] s,
                           input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_size  = '0;
    cmd_wdata = '0;
    bus_if.HREADY = 1'b1;
    bus_if.HRESP  = 1'b0;
    bus_if.HRDATA = 32'h1234_5678;

    #12;
    check("rst_htrans", 32'(bus_if.HTRANS), 0);
    check("rst_haddr",  bus_if.HADDR, 0);
    check("rst_hwdata", bus_if.HWDATA, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("hburst", 32'(bus_if.HBURST), 0);
    check("hprot", 32'(bus_if.HPROT), 32'h3);
    @(negedge HCLK) HRESETn = 1'b1;
    tick();

    // Word write, zero waits: NONSEQ, then data, then response.
    drive_cmd(1'b1, 32'h5000_0000, HSIZE_WORD, 32'h0000_A5A5);
    check("t1_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    check("t1_htrans", 32'(bus_if.HTRANS), 32'h2);
    check("t1_haddr",  bus_if.HADDR, 32'h5000_0000);
    check("t1_hwrite", 32'(bus_if.HWRITE), 1);
    check("t1_hsize",  32'(bus_if.HSIZE), 32'h2);
    tick();
    check("t1_htrans_idle", 32'(bus_if.HTRANS), 0);
    check("t1_hwdata", bus_if.HWDATA, 32'h0000_A5A5);
    check("t1_rsp_early", 32'(rsp_valid), 0);
    tick();
    check("t1_rsp_valid", 32'(rsp_valid), 1);
    check("t1_rsp_err", 32'(rsp_err), 0);
    check("t1_rsp_rdata", rsp_rdata, 0);
    tick();
    check("t1_rsp_pulse", 32'(rsp_valid), 0);

    // Byte read from lane 3.
    drive_cmd(1'b0, 32'h5000_0003, HSIZE_BYTE, 32'h0);
    tick();
    cmd_valid = 1'b0;
    check("t2_hsize", 32'(bus_if.HSIZE), 0);
    check("t2_hwrite", 32'(bus_if.HWRITE), 0);
    tick();
    tick();
    check("t2_rsp_valid", 32'(rsp_valid), 1);
    check("t2_rsp_rdata", rsp_rdata, 32'h0000_0012);

    // Byte write with junk above the significant byte.
    drive_cmd(1'b1, 32'h5000_0002, HSIZE_BYTE, 32'hFFFF_FF3C);
    tick();
    cmd_valid = 1'b0;
    check("t3_hsize", 32'(bus_if.HSIZE), 0);
    check("t3_haddr", bus_if.HADDR, 32'h5000_0002);
    tick();
    check("t3_hwdata", bus_if.HWDATA, 32'h3C3C_3C3C);
    tick();
    check("t3_rsp_valid", 32'(rsp_valid), 1);
    tick();

    // Halfword write, upper half.
    drive_cmd(1'b1, 32'h5000_0006, HSIZE_HALF, 32'h0000_BEEF);
    tick();
    cmd_valid = 1'b0;
    tick();
    check("t3h_hwdata", bus_if.HWDATA, 32'hBEEF_BEEF);
    tick();
    tick();

    // Four back-to-back word writes.
    rsp_q.delete();
    for (int i = 0; i < 4; i++) begin
      drive_cmd(1'b1, 32'h5000_0100 + 32'(4 * i), HSIZE_WORD, 32'h1111_0000 + 32'(i));
      tick();
      check($sformatf("t4_htrans%0d", i), 32'(bus_if.HTRANS), 32'h2);
      check($sformatf("t4_haddr%0d", i), bus_if.HADDR, 32'h5000_0100 + 32'(4 * i));
      if (i > 0)
        check($sformatf("t4_hwdata%0d", i - 1), bus_if.HWDATA, 32'h1111_0000 + 32'(i - 1));
    end
    cmd_valid = 1'b0;
    tick();
    check("t4_hwdata3", bus_if.HWDATA, 32'h1111_0003);
    check("t4_htrans_idle", 32'(bus_if.HTRANS), 0);
    tick();
    tick();
    tick();
    check("t4_rsp_count", 32'(rsp_q.size()), 4);
    for (int i = 1; i < rsp_q.size(); i++)
      check($sformatf("t4_rsp_cyc%0d", i), 32'(rsp_q[i].cyc), 32'(rsp_q[0].cyc + i));

    // Read held by two wait states while a write sits in the address phase.
    rsp_q.delete();
    drive_cmd(1'b0, 32'h5000_0010, HSIZE_WORD, 32'h0);
    tick();
    drive_cmd(1'b1, 32'h5000_0020, HSIZE_WORD, 32'hCAFE_F00D);
    tick();
    cmd_valid = 1'b0;
    bus_if.HREADY = 1'b0;
    bus_if.HRDATA = 32'hDEAD_DEAD;
    #1;
    check("t5_ready_low", 32'(cmd_ready), 0);
    check("t5_htrans_w0", 32'(bus_if.HTRANS), 32'h2);
    tick();
    check("t5_haddr_w1", bus_if.HADDR, 32'h5000_0020);
    check("t5_htrans_w1", 32'(bus_if.HTRANS), 32'h2);
    check("t5_rsp_w1", 32'(rsp_valid), 0);
    tick();
    bus_if.HREADY = 1'b1;
    bus_if.HRDATA = 32'h8765_4321;
    check("t5_haddr_w2", bus_if.HADDR, 32'h5000_0020);
    check("t5_rsp_w2", 32'(rsp_valid), 0);
    tick();
    check("t5_rsp_rd", 32'(rsp_valid), 1);
    check("t5_rdata", rsp_rdata, 32'h8765_4321);
    check("t5_hwdata", bus_if.HWDATA, 32'hCAFE_F00D);
    check("t5_htrans_idle", 32'(bus_if.HTRANS), 0);
    tick();
    check("t5_rsp_wr", 32'(rsp_valid), 1);
    check("t5_rsp_wr_rdata", rsp_rdata, 0);
    tick();
    tick();
    check("t5_rsp_count", 32'(rsp_q.size()), 2);

    // ERROR on a read with a write queued behind it.
    rsp_q.delete();
    bus_if.HRDATA = 32'h0;
    drive_cmd(1'b0, 32'h5000_0030, HSIZE_WORD, 32'h0);
    tick();
    drive_cmd(1'b1, 32'h5000_0034, HSIZE_WORD, 32'h5555_AAAA);
    tick();
    cmd_valid = 1'b0;
    bus_if.HREADY = 1'b0;
    bus_if.HRESP  = 1'b1;
    #1;
    check("t6_htrans_c1", 32'(bus_if.HTRANS), 32'h2);
    check("t6_ready_c1", 32'(cmd_ready), 0);
    tick();
    bus_if.HREADY = 1'b1;
    #1;
    check("t6_htrans_c2", 32'(bus_if.HTRANS), 0);
    check("t6_ready_c2", 32'(cmd_ready), 0);
    tick();
    bus_if.HRESP = 1'b0;
    check("t6_rsp1_valid", 32'(rsp_valid), 1);
    check("t6_rsp1_err", 32'(rsp_err), 1);
    check("t6_rsp1_abort", 32'(rsp_abort), 0);
    tick();
    check("t6_rsp2_valid", 32'(rsp_valid), 1);
    check("t6_rsp2_err", 32'(rsp_err), 1);
    check("t6_rsp2_abort", 32'(rsp_abort), 1);
    check("t6_rsp2_rdata", rsp_rdata, 0);
    tick();
    check("t6_rsp_done", 32'(rsp_valid), 0);
    check("t6_rsp_count", 32'(rsp_q.size()), 2);

    // Recovery: halfword read from the upper half.
    bus_if.HRDATA = 32'h1234_5678;
    drive_cmd(1'b0, 32'h5000_0042, HSIZE_HALF, 32'h0);
    check("t6r_ready", 32'(cmd_ready), 1);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("t6r_rsp_valid", 32'(rsp_valid), 1);
    check("t6r_rsp_err", 32'(rsp_err), 0);
    check("t6r_rdata", rsp_rdata, 32'h0000_1234);
    tick();

    // Reset in the middle of an overlapped pair of writes.
    rsp_q.delete();
    drive_cmd(1'b1, 32'h5000_0050, HSIZE_WORD, 32'h7777_7777);
    tick();
    drive_cmd(1'b1, 32'h5000_0054, HSIZE_WORD, 32'h8888_8888);
    tick();
    cmd_valid = 1'b0;
    #2;
    HRESETn = 1'b0;
    #1;
    check("t7_htrans", 32'(bus_if.HTRANS), 0);
    check("t7_haddr", bus_if.HADDR, 0);
    check("t7_hwdata", bus_if.HWDATA, 0);
    check("t7_rsp_valid", 32'(rsp_valid), 0);
    tick();
    tick();
    @(negedge HCLK) HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("t7_no_rsp", 32'(rsp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
